mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Control unit for the 32-bit multicycle MIPS datapath.
- Sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states using a Moore main FSM plus a combinational ALU decoder.
- Drives every datapath mux select and write enable.
- Generates the gated PC enable from PCWrite, Branch and the ALU zero flag.

Parameters:
- OP_W, 6, opcode and funct field width.
- ALUCTL_W, 3, ALUControl width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  instruction register bits [31:26].
- funct  in  6  instruction register bits [5:0].
- zero  in  1  ALU zero flag, combinational from the current ALU result.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  register destination select: 0 = rt, 1 = rd.
- MemtoReg  out  1  write-data select: 0 = ALUOut, 1 = Data register.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable = PCWrite | (Branch & zero).
- state_o  out  4  current state encoding, for debug.

Behaviour:
- One clock: clk. Reset is synchronous and active-high: on a rising edge of clk with reset=1, state <= FETCH.
- While reset=1, IRWrite, PCEn, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Outputs are pure functions of the state, except ALUControl (state + funct) and PCEn (state + zero).
- Any output not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH (treated as NOP; PC has already advanced)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if op=lw, else MEMWR.
- MEMRD: IorD=1. Next state: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state: FETCH.
- MEMWR: IorD=1, MemWrite=1. Next state: FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next state: FETCH.
  - PCEn is high only when zero=1 in this cycle.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state: FETCH.
- ALU decoder:
  - ALUOp=00 -> add (010).
  - ALUOp=01 -> sub (110).
  - ALUOp=10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct -> 010 (add), with RegWrite unchanged.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Reset asserted mid-instruction aborts it: no write enable is asserted in the reset cycle, and FETCH begins on the cycle after reset deasserts.
- The unused state encodings 12-15 go to FETCH on the next edge, with all write enables 0 while in them.

Optional Feature:
- Macro: MIPS_CTRL_JUMP_EN.
- Defined: JUMP state exists, and op=000010 goes DECODE->JUMP with PCSrc=10.
- Undefined: no JUMP state, op=000010 is illegal (DECODE->FETCH), and PCSrc[1] is tied to 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUOp codes
  - ALUControl codes
- One sub-module, alu_decoder: combinational (ALUOp, funct) -> ALUControl.
- The FSM stays in mips_multicycle_ctrl.

Test Plan:
- Reset held for 2 cycles, then released with op=100011 -> state_o sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. PCEn=1 only in state 0.
- op=101011 -> sequence 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5 only. RegWrite never asserted.
- op=000000 with funct=101010 -> ALUControl=111 in EXECUTE. ALUWB has RegDst=1, RegWrite=1.
- op=000100 with zero=1 in BRANCH -> PCEn=1, PCSrc=01. Repeat with zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- op=111111 -> DECODE then FETCH, no write enables asserted. op=000010 -> JUMP with PCSrc=10, PCEn=1 when MIPS_CTRL_JUMP_EN is defined; otherwise treated as illegal.
- reset=1 asserted during MEMRD -> next state FETCH, MemWrite/RegWrite/PCEn/IRWrite all 0 in the reset cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multicycle MIPS control unit: the 4-bit state
//   encoding, opcode and funct field values, ALUOp codes, ALUControl codes,
//   and the select codes for the ALU B input and the PC source mux.
//   No ports; imported by mips_multicycle_ctrl and alu_decoder.
//   The JUMP state value is always defined here. Whether the controller ever
//   enters it depends on the MIPS_CTRL_JUMP_EN macro in the top module.
package mips_ctrl_pkg;

  // Main FSM states. Values 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // ALUOp tells the ALU decoder whether to force add, force subtract, or look at funct.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct field values for R-type (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl encodings understood by the datapath ALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// alu_decoder
//   Combinational ALU decoder. It maps ALUOp and the R-type funct field onto
//   the ALUControl code that drives the ALU.
//   Ports:
//     i_aluOp      in   2         add / sub / decode-funct request from the FSM
//     i_funct      in   OP_W      instruction funct field
//     o_aluControl out  ALUCTL_W  ALU operation select
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUCTL_W = 3
) (
  input  aluop_t              i_aluOp,
  input  logic [OP_W-1:0]     i_funct,
  output logic [ALUCTL_W-1:0] o_aluControl
);

  // Address arithmetic and the branch compare force add or sub. Only EXECUTE
  // asks for the funct field. An unrecognised funct falls back to add, so the
  // instruction still writes back a harmless sum instead of an undefined code.
  always_comb begin
    o_aluControl = ALU_ADD;
    case (i_aluOp)
      ALUOP_ADD: o_aluControl = ALU_ADD;
      ALUOP_SUB: o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_aluControl = ALU_ADD;
          FN_SUB:  o_aluControl = ALU_SUB;
          FN_AND:  o_aluControl = ALU_AND;
          FN_OR:   o_aluControl = ALU_OR;
          FN_SLT:  o_aluControl = ALU_SLT;
          default: o_aluControl = ALU_ADD;
        endcase
      end
      default: o_aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Control unit for the 32-bit multicycle MIPS datapath. A Moore main FSM
//   steps each instruction through fetch/decode/execute/memory/writeback. The
//   alu_decoder sub-module produces ALUControl.
//   Optional feature macro: MIPS_CTRL_JUMP_EN. When it is defined, op=000010
//   (j) uses the JUMP state. When it is undefined, j is handled as an illegal
//   opcode and PCSrc[1] is held at 0.
//   Ports:
//     clk        in   1         system clock, rising edge
//     reset      in   1         synchronous active-high reset
//     op         in   OP_W      instr[31:26]
//     funct      in   OP_W      instr[5:0]
//     zero       in   1         ALU zero flag
//     IorD       out  1         memory address select (0 PC, 1 ALUOut)
//     MemWrite   out  1         memory write enable
//     IRWrite    out  1         instruction register load
//     RegDst     out  1         destination select (0 rt, 1 rd)
//     MemtoReg   out  1         write-data select (0 ALUOut, 1 Data)
//     RegWrite   out  1         register file write enable
//     ALUSrcA    out  1         ALU A select (0 PC, 1 A)
//     ALUSrcB    out  2         ALU B select (B, 4, SignImm, SignImm<<2)
//     ALUControl out  ALUCTL_W  ALU operation
//     PCSrc      out  2         PC source (ALUResult, ALUOut, jump target)
//     PCEn       out  1         PC load enable
//     state_o    out  4         current state, for debug
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [OP_W-1:0]     funct,
  input  logic                zero,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          PCSrc,
  output logic                PCEn,
  output logic [3:0]          state_o
);

  state_t r_state;
  state_t w_nextState;
  state_t w_outState;
  aluop_t w_aluOp;
  logic   w_pcWrite;
  logic   w_branch;

  // State register. Reset is synchronous, so an instruction that is aborted
  // still spends its reset cycle in its current state. The output logic below
  // masks that cycle.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_nextState;
  end

  // Next-state logic. Opcodes the controller does not implement return to
  // FETCH right after DECODE. The PC was already advanced in FETCH, so such an
  // opcode acts as a two-cycle NOP. Unused encodings also fall back to FETCH.
  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_RTYPE:     w_nextState = S_EXECUTE;
          OP_BEQ:       w_nextState = S_BRANCH;
          OP_ADDI:      w_nextState = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:         w_nextState = S_JUMP;
`endif
          default:      w_nextState = S_FETCH;
        endcase
      end
      S_MEMADR:  w_nextState = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_nextState = S_MEMWB;
      S_MEMWB:   w_nextState = S_FETCH;
      S_MEMWR:   w_nextState = S_FETCH;
      S_EXECUTE: w_nextState = S_ALUWB;
      S_ALUWB:   w_nextState = S_FETCH;
      S_BRANCH:  w_nextState = S_FETCH;
      S_ADDIEX:  w_nextState = S_ADDIWB;
      S_ADDIWB:  w_nextState = S_FETCH;
      default:   w_nextState = S_FETCH;
    endcase
  end

  // Moore output decode. During reset the mux selects show FETCH values,
  // whatever state the register still holds. The write enables are then
  // cleared, so an aborted instruction cannot change architectural state.
  // Branch and PCWrite are combined with zero at the end to form PCEn.
  always_comb begin
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    PCSrc     = PCSRC_ALURES;
    w_aluOp   = ALUOP_ADD;
    w_pcWrite = 1'b0;
    w_branch  = 1'b0;
    w_outState = reset ? S_FETCH : r_state;
    case (w_outState)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        IRWrite   = 1'b1;
        w_pcWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluOp = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluOp  = ALUOP_SUB;
        PCSrc    = PCSRC_ALUOUT;
        w_branch = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        PCSrc     = PCSRC_JUMP;
        w_pcWrite = 1'b1;
      end
`endif
      default: begin
      end
    endcase
`ifndef MIPS_CTRL_JUMP_EN
    PCSrc[1] = 1'b0;
`endif
    if (reset) begin
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      w_pcWrite = 1'b0;
      w_branch  = 1'b0;
    end
    PCEn = w_pcWrite | (w_branch & zero);
  end

  assign state_o = r_state;

  alu_decoder #(
    .OP_W    (OP_W),
    .ALUCTL_W(ALUCTL_W)
  ) u_aluDecoder (
    .i_aluOp     (w_aluOp),
    .i_funct     (funct),
    .o_aluControl(ALUControl)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl. For each instruction class,
//   a reference model lists the cycles that instruction should take and the
//   control word it should produce in each cycle. The bench checks the DUT
//   against that list, first with directed instructions and then with
//   randomly chosen ones. It honours MIPS_CTRL_JUMP_EN in the same way as
//   the design.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       iord;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluCtl;
    logic [1:0] pcSrc;
    logic       pcEn;
  } outs_t;

  typedef struct {
    int    st;
    outs_t o;
    bit    branchDep;
  } cyc_t;

  cyc_t  expQ[$];
  outs_t obs;

  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCEn};

  mips_multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // A cycle that does nothing: every control is 0 and the ALU adds.
  function automatic cyc_t blank(int st);
    cyc_t c;
    c.st        = st;
    c.o         = '0;
    c.o.aluCtl  = 3'b010;
    c.branchDep = 1'b0;
    return c;
  endfunction

  // The ALU operation an R-type instruction asks for through its funct field.
  function automatic logic [2:0] functCtl(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference model: the cycle-by-cycle story of a single instruction.
  task automatic buildTrace(input logic [5:0] o, input logic [5:0] f);
    cyc_t c;
    expQ.delete();
    c = blank(0); c.o.irWrite = 1; c.o.pcEn = 1; c.o.aluSrcB = 2'b01; expQ.push_back(c);
    c = blank(1); c.o.aluSrcB = 2'b11; expQ.push_back(c);
    case (o)
      6'b100011: begin
        c = blank(2); c.o.aluSrcA = 1; c.o.aluSrcB = 2'b10; expQ.push_back(c);
        c = blank(3); c.o.iord = 1; expQ.push_back(c);
        c = blank(4); c.o.memtoReg = 1; c.o.regWrite = 1; expQ.push_back(c);
      end
      6'b101011: begin
        c = blank(2); c.o.aluSrcA = 1; c.o.aluSrcB = 2'b10; expQ.push_back(c);
        c = blank(5); c.o.iord = 1; c.o.memWrite = 1; expQ.push_back(c);
      end
      6'b000000: begin
        c = blank(6); c.o.aluSrcA = 1; c.o.aluCtl = functCtl(f); expQ.push_back(c);
        c = blank(7); c.o.regDst = 1; c.o.regWrite = 1; expQ.push_back(c);
      end
      6'b000100: begin
        c = blank(8); c.o.aluSrcA = 1; c.o.aluCtl = 3'b110; c.o.pcSrc = 2'b01;
        c.branchDep = 1; expQ.push_back(c);
      end
      6'b001000: begin
        c = blank(9); c.o.aluSrcA = 1; c.o.aluSrcB = 2'b10; expQ.push_back(c);
        c = blank(10); c.o.regWrite = 1; expQ.push_back(c);
      end
`ifdef MIPS_CTRL_JUMP_EN
      6'b000010: begin
        c = blank(11); c.o.pcSrc = 2'b10; c.o.pcEn = 1; expQ.push_back(c);
      end
`endif
      default: begin
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input int expSt, input outs_t expO);
    checks++;
    assert (state_o === 4'(expSt)) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_o, expSt);
    end
    checks++;
    assert (obs === expO) else begin
      errors++;
      $error("FAIL %s controls: observed %h expected %h", tag, obs, expO);
    end
  endtask

  // Runs one instruction from its FETCH cycle onward. zMode < 0 drives zero
  // randomly each cycle, otherwise it is held at zMode. The DUT is sampled
  // at the falling edge.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input int zMode, input string tag);
    outs_t e;
    buildTrace(o, f);
    op    = o;
    funct = f;
    foreach (expQ[i]) begin
      zero = (zMode < 0) ? 1'($urandom_range(0, 1)) : 1'(zMode);
      #4;
      e = expQ[i].o;
      if (expQ[i].branchDep) e.pcEn = zero;
      checkOutput($sformatf("%s[%0d]", tag, i), expQ[i].st, e);
      @(posedge clk);
      #1;
    end
  endtask

  // Under reset the selects show FETCH values and every enable is 0.
  function automatic outs_t resetOuts();
    outs_t r;
    r         = '0;
    r.aluSrcB = 2'b01;
    r.aluCtl  = 3'b010;
    return r;
  endfunction

  logic [5:0] opPool[7];
  logic [5:0] fnPool[5];

  initial begin
    opPool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fnPool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset held for two cycles with zero high, so PCEn has to be masked.
    reset = 1'b1;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b1;
    @(posedge clk); #1;
    #4 checkOutput("reset0", 0, resetOuts());
    @(posedge clk); #1;
    #4 checkOutput("reset1", 0, resetOuts());
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed instruction classes
    applyStimulus(6'b100011, 6'b000000, -1, "lw");
    applyStimulus(6'b101011, 6'b000000, -1, "sw");
    applyStimulus(6'b000000, 6'b101010, -1, "rtype_slt");
    applyStimulus(6'b000000, 6'b111000, -1, "rtype_badfn");
    applyStimulus(6'b000100, 6'b000000, 1, "beq_taken");
    applyStimulus(6'b000100, 6'b000000, 0, "beq_nottaken");
    applyStimulus(6'b001000, 6'b000000, -1, "addi");
    applyStimulus(6'b111111, 6'b000000, 1, "illegal");
    applyStimulus(6'b000010, 6'b000000, 1, "jump");

    // lw aborted by a reset asserted in MEMRD
    buildTrace(6'b100011, 6'b000000);
    op = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      zero = 1'b0;
      #4 checkOutput($sformatf("abort[%0d]", i), expQ[i].st, expQ[i].o);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    zero  = 1'b1;
    #4 checkOutput("abort_rst", 3, resetOuts());
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(6'b101011, 6'b000000, -1, "after_abort");

    // Randomly chosen instructions with random funct and zero values
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      logic [5:0] f;
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : opPool[$urandom_range(0, 6)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnPool[$urandom_range(0, 4)];
      applyStimulus(o, f, -1, $sformatf("rnd%0d_op%b", n, o));
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
